// File: rtl/kv_fpu_pkg.sv
// Shared FPU datapath constants and the carry-save reference resolver.
package kv_fpu_pkg;

  localparam int KV_CSA_WIDTH_DEF = 32;
  localparam int KV_CSA_SEG_W_DEF = 8;

  // Golden value of a carry-save pair: sum + (cout << 1).
  function automatic logic [KV_CSA_WIDTH_DEF+1:0] kv_csa_ref(
    input logic [KV_CSA_WIDTH_DEF-1:0] sum_v,
    input logic [KV_CSA_WIDTH_DEF-1:0] cout_v
  );
    return {2'b00, sum_v} + {1'b0, cout_v, 1'b0};
  endfunction

endpackage

// File: rtl/kv_csa_resolve_seg.sv
// One ripple slice of the carry-save resolver: W-bit add with carry in/out.
module kv_csa_resolve_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  logic [W:0] total;

  assign total    = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
  assign {c_o, s_o} = total;

endmodule

// File: rtl/kv_csa_resolve.sv
// Pipelined carry-save to binary resolver: one SEG_W-bit ripple slice per stage,
// bubble-collapsing valid/ready chain, result = in_sum + 2*in_cout.
module kv_csa_resolve
  import kv_fpu_pkg::*;
#(
  parameter int CSA_WIDTH = KV_CSA_WIDTH_DEF,
  parameter int SEG_W     = KV_CSA_SEG_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CSA_WIDTH-1:0] in_sum,
  input  logic [CSA_WIDTH-1:0] in_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CSA_WIDTH+1:0] out_res
);

  localparam int STAGES = CSA_WIDTH / SEG_W;
  localparam int OP_W   = CSA_WIDTH + 1;
  localparam int RES_W  = CSA_WIDTH + 2;

  logic [STAGES-1:0] valid_q;
  logic [STAGES:0]   vchain;
  logic [STAGES:0]   stage_ready;
  logic [STAGES-1:0] load_en;

  // vchain[k] is the valid bit offered to stage k; vchain[STAGES] is the output.
  assign vchain    = {valid_q, in_valid};
  assign out_valid = vchain[STAGES];
  assign in_ready  = stage_ready[0];
  assign load_en   = stage_ready[STAGES-1:0] & vchain[STAGES-1:0];

  always_comb begin
    stage_ready         = '0;
    stage_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !valid_q[k] || stage_ready[k+1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= vchain[k];
        end
      end
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO   = gi * SEG_W;
    localparam bit LAST = (gi == STAGES - 1);
    // The last slice also absorbs operand bit CSA_WIDTH.
    localparam int W    = LAST ? SEG_W + 1 : SEG_W;
    localparam int IN_W = OP_W - LO;

    logic [IN_W-1:0]   a_in;
    logic [IN_W-1:0]   b_in;
    logic              c_in;
    logic [W-1:0]      s;
    logic              c_out;
    logic [LO+W-1:0]   res_d;

    if (gi == 0) begin : g_src
      assign a_in  = {1'b0, in_sum};
      assign b_in  = {in_cout, 1'b0};
      assign c_in  = 1'b0;
      assign res_d = s;
    end else begin : g_src
      assign a_in  = g_stage[gi-1].g_op.a_q;
      assign b_in  = g_stage[gi-1].g_op.b_q;
      assign c_in  = g_stage[gi-1].g_op.carry_q;
      assign res_d = {s, g_stage[gi-1].g_op.res_q};
    end

    kv_csa_resolve_seg #(
      .W (W)
    ) u_seg (
      .a_i (a_in[W-1:0]),
      .b_i (b_in[W-1:0]),
      .c_i (c_in),
      .s_o (s),
      .c_o (c_out)
    );

    if (!LAST) begin : g_op
      logic [IN_W-W-1:0] a_q;
      logic [IN_W-W-1:0] b_q;
      logic              carry_q;
      logic [LO+W-1:0]   res_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q     <= '0;
          b_q     <= '0;
          carry_q <= 1'b0;
          res_q   <= '0;
        end else if (load_en[gi]) begin
          a_q     <= a_in[IN_W-1:W];
          b_q     <= b_in[IN_W-1:W];
          carry_q <= c_out;
          res_q   <= res_d;
        end
      end
    end else begin : g_out
      logic [RES_W-1:0] res_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          res_q <= '0;
        end else if (load_en[gi]) begin
          res_q <= {c_out, res_d};
        end
      end
    end
  end

  assign out_res = g_stage[STAGES-1].g_out.res_q;

endmodule
